// File: rtl/pipeline_trace_buffer.sv
// pipeline_trace_buffer: retirement trace capture plus saturating event counters
// for the MEM/WB stage of the 5-stage pipeline.
// Optional build macro TRACE_FILTER_X0_EN: when defined, retirements writing x0
// are not recorded, do not advance the post-trigger countdown and cannot trigger.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | nothing recorded, waiting for arm
// ARMED     | recording into the circular buffer, watching for trigger PC
// TRIGGERED | recording the post-trigger window, post_left records to go
// DONE      | buffer frozen until the next arm
module pipeline_trace_buffer #(
   parameter int XLEN  = 64,
   parameter int DEPTH = 16,
   parameter int CNT_W = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wb_valid,
   input  logic [XLEN-1:0]          wb_pc,
   input  logic [4:0]               wb_rd,
   input  logic [XLEN-1:0]          wb_data,
   input  logic                     stall,
   input  logic                     flush,
   input  logic                     arm,
   input  logic                     trig_en,
   input  logic [XLEN-1:0]          trig_pc,
   input  logic [$clog2(DEPTH)-1:0] post_cnt,
   input  logic                     clr_cnt,
   input  logic                     rd_req,
   input  logic [$clog2(DEPTH)-1:0] rd_idx,
   output logic                     rd_valid,
   output logic [XLEN-1:0]          rd_pc,
   output logic [4:0]               rd_rd,
   output logic [XLEN-1:0]          rd_data,
   output logic [1:0]               trc_state,
   output logic [$clog2(DEPTH):0]   entry_count,
   output logic [CNT_W-1:0]         cyc_cnt,
   output logic [CNT_W-1:0]         ret_cnt,
   output logic [CNT_W-1:0]         stall_cnt,
   output logic [CNT_W-1:0]         flush_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ARMED     = 2'd1,
      TRIGGERED = 2'd2,
      DONE      = 2'd3
   } trc_state_t;

   trc_state_t      state, state_nxt;
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   post_left, post_nxt;
   logic            rec;
   logic            eligible;
   logic            trig_hit;
   logic [AW-1:0]   rd_addr;
   logic            rd_hit;

   logic [XLEN-1:0] mem_pc   [DEPTH];
   logic [4:0]      mem_rd   [DEPTH];
   logic [XLEN-1:0] mem_data [DEPTH];

`ifdef TRACE_FILTER_X0_EN
   assign eligible = wb_valid && (wb_rd != 5'd0);
`else
   assign eligible = wb_valid;
`endif

   assign trig_hit  = trig_en && (wb_pc == trig_pc);
   assign trc_state = state;

   // Next-state logic: arm always wins, otherwise record while armed/triggered.
   always_comb begin
      state_nxt = state;
      post_nxt  = post_left;
      rec       = 1'b0;
      if (arm) begin
         state_nxt = ARMED;
         post_nxt  = '0;
      end else begin
         case (state)
            ARMED: begin
               if (eligible) begin
                  rec = 1'b1;
                  if (trig_hit) begin
                     if (post_cnt == '0) begin
                        state_nxt = DONE;
                     end else begin
                        post_nxt  = post_cnt;
                        state_nxt = TRIGGERED;
                     end
                  end
               end
            end
            TRIGGERED: begin
               if (eligible) begin
                  rec      = 1'b1;
                  post_nxt = post_left - 1'b1;
                  if (post_left <= 1) state_nxt = DONE;
               end
            end
            default: ;
         endcase
      end
   end

   // Capture control registers: state, write pointer, fill level, post-trigger countdown.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         wr_ptr      <= '0;
         entry_count <= '0;
         post_left   <= '0;
      end else begin
         state     <= state_nxt;
         post_left <= post_nxt;
         if (arm) begin
            wr_ptr      <= '0;
            entry_count <= '0;
         end else if (rec) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (entry_count != FULL) entry_count <= entry_count + 1'b1;
         end
      end
   end

   // Trace storage; contents are don't-care after reset so no reset here.
   always_ff @(posedge clk) begin
      if (rec) begin
         mem_pc[wr_ptr]   <= wb_pc;
         mem_rd[wr_ptr]   <= wb_rd;
         mem_data[wr_ptr] <= wb_data;
      end
   end

   // Index 0 is the oldest entry; modulo wrap comes free from the AW-bit width.
   assign rd_addr = wr_ptr - entry_count[AW-1:0] + rd_idx;
   assign rd_hit  = ({1'b0, rd_idx} < entry_count);

   // Registered readout: reads sample pre-edge storage, so a same-cycle write is not seen.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_valid <= 1'b0;
         rd_pc    <= '0;
         rd_rd    <= '0;
         rd_data  <= '0;
      end else begin
         rd_valid <= rd_req;
         if (rd_req) begin
            if (rd_hit) begin
               rd_pc   <= mem_pc[rd_addr];
               rd_rd   <= mem_rd[rd_addr];
               rd_data <= mem_data[rd_addr];
            end else begin
               rd_pc   <= '0;
               rd_rd   <= '0;
               rd_data <= '0;
            end
         end
      end
   end

   function automatic logic [CNT_W-1:0] sat_next(input logic [CNT_W-1:0] cnt,
                                                 input logic inc, input logic clr);
      if (clr)                      return '0;
      else if (inc && (cnt != '1))  return cnt + 1'b1;
      else                          return cnt;
   endfunction

   // Saturating performance counters; clear beats increment, arm leaves them alone.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cyc_cnt   <= '0;
         ret_cnt   <= '0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         cyc_cnt   <= sat_next(cyc_cnt, 1'b1, clr_cnt);
         ret_cnt   <= sat_next(ret_cnt, wb_valid, clr_cnt);
         stall_cnt <= sat_next(stall_cnt, stall, clr_cnt);
         flush_cnt <= sat_next(flush_cnt, flush, clr_cnt);
      end
   end

endmodule

// File: doc/pipeline_trace_buffer.md
Name: pipeline_trace_buffer

Overview:
- Synthesizable retirement-trace and performance-counter block for the 5-stage RISC-V pipeline. It replaces per-cycle simulation printing with on-chip capture.
- Taps the MEM/WB write-back stage: PC, rd address and write data of each retiring instruction, plus stall and branch-flush strobes.
- Records retirements into a parametrised circular buffer with arm/trigger/post-trigger control.
- Provides a readout port and saturating event counters for cycles, retirements, stalls and flushes.

Parameters:
- XLEN, 64, width of write-back data and PC.
- DEPTH, 16, trace entries; power of two, minimum 4.
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- wb_valid  in  1  a register-writing instruction retires this cycle.
- wb_pc  in  XLEN  PC of the retiring instruction.
- wb_rd  in  5  destination register.
- wb_data  in  XLEN  value written to rd.
- stall  in  1  pipeline stall strobe.
- flush  in  1  branch-taken flush strobe.
- arm  in  1  pulse: (re)start a capture.
- trig_en  in  1  enables PC-match trigger.
- trig_pc  in  XLEN  trigger PC.
- post_cnt  in  $clog2(DEPTH)  records to capture after the trigger record.
- clr_cnt  in  1  synchronous clear of all counters.
- rd_req  in  1  readout request.
- rd_idx  in  $clog2(DEPTH)  entry index, 0 = oldest.
- rd_valid  out  1  readout data valid.
- rd_pc  out  XLEN  PC field of the read entry.
- rd_rd  out  5  rd field of the read entry.
- rd_data  out  XLEN  data field of the read entry.
- trc_state  out  2  IDLE=0, ARMED=1, TRIGGERED=2, DONE=3.
- entry_count  out  $clog2(DEPTH)+1  number of valid entries.
- cyc_cnt  out  CNT_W  cycle counter.
- ret_cnt  out  CNT_W  retirement counter.
- stall_cnt  out  CNT_W  stall counter.
- flush_cnt  out  CNT_W  flush counter.

Behaviour:
- Reset (async): trc_state=IDLE; wr_ptr=0; entry_count=0; post_left=0; rd_valid=0; rd_pc, rd_rd, rd_data = 0; all counters 0. Buffer contents are don't-care.
- A retirement is eligible when wb_valid=1, subject to the optional filter.
- IDLE: nothing is recorded. arm -> ARMED.
- arm pulse, any state: wr_ptr=0, entry_count=0, state=ARMED. arm has priority; a retirement in the same cycle is not recorded.
- ARMED, eligible retirement:
  - Write {wb_pc, wb_rd, wb_data} to buf[wr_ptr]; wr_ptr increments modulo DEPTH.
  - entry_count increments, saturating at DEPTH (oldest entry overwritten).
  - If trig_en=1 and wb_pc==trig_pc, the record is still written. Then:
    - post_cnt==0 -> DONE.
    - otherwise post_left=post_cnt and state -> TRIGGERED.
- TRIGGERED, eligible retirement: record as in ARMED; post_left decrements; when it reaches 0 -> DONE after that write. A trigger match here is ignored.
- DONE: no writes; buffer frozen until the next arm.
- Readout:
  - rd_req sampled at the clock edge; one-cycle latency; rd_valid pulses high for exactly one cycle.
  - Physical address = (wr_ptr - entry_count + rd_idx) mod DEPTH, using the pre-edge wr_ptr and entry_count.
  - rd_idx >= entry_count -> rd_valid=1 with all fields 0.
  - A read colliding with a write in the same cycle returns the pre-write content.
  - Readout is allowed in every state.
  - Fields hold their value until the next rd_req.
- Counters:
  - cyc_cnt increments every cycle.
  - ret_cnt increments on wb_valid (unfiltered).
  - stall_cnt increments on stall; flush_cnt increments on flush.
  - All saturate at 2^CNT_W-1.
  - clr_cnt zeroes all four and has priority over increment in the same cycle.
  - arm does not affect counters.
- Reset mid-capture: immediate return to IDLE; entry_count reads 0.

Optional Feature:
- Macro TRACE_FILTER_X0_EN.
- Defined: retirements with wb_rd==0 are not eligible for recording and do not decrement post_left. A trigger PC match on such a retirement is ignored. ret_cnt still counts them.
- Undefined: every wb_valid retirement is eligible.

Test Plan:
- DEPTH=8. arm, then 10 retirements with PC 0x00,0x04..0x24 and trig_en=0 -> trc_state=1, entry_count=8; rd_idx=0 returns pc 0x08; rd_idx=7 returns pc 0x24.
- arm, trig_pc=0x10, post_cnt=2, retire PC 0x00..0x20 -> DONE after the 0x18 record; entry_count=7; rd_idx=6 returns 0x18; 0x1C and 0x20 are not recorded.
- post_cnt=0, trigger at PC 0x08 -> trc_state=3 the cycle after the 0x08 write; entry_count=3.
- stall=1 for 5 cycles, two flush pulses, then clr_cnt coincident with stall=1 -> before clear stall_cnt=5, flush_cnt=2; after clear all counters read 0.
- Reset asserted while TRIGGERED with post_left=3 -> trc_state=0, entry_count=0, rd_valid=0 immediately; rd_req with rd_idx=0 after arm and no retirements -> rd_valid=1, fields 0.
- With TRACE_FILTER_X0_EN: retire rd=0 pc 0x40, then rd=5 pc 0x44 -> entry_count=1, ret_cnt=2. Without the macro -> entry_count=2.
